cdb_arbiter: RTL and testbench

- Sits directly downstream of the functional units and the issue unit.
- Holds one completed result per FU in a holding slot and picks one slot per cycle, round-robin, to broadcast on the common data bus (CDB).
- Drives back to the issue unit:
  - per-FU "result pending" (insns_ready)
  - per-FU grant (cdb_select)
- The issue unit uses these so it only dispatches to an FU whose slot is empty or draining this cycle.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter_rr_arbiter.sv | 28 ++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter definitions: FU slot indices, default widths and the CDB packet.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_FU = 4;
    localparam int CDB_XLEN   = 32;
    localparam int CDB_TAG_W  = 6;

    // Slot index of each functional unit; bit i of every per-FU vector belongs to FU i.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BR  = 2'd3
    } fu_idx_e;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-completion / CDB-broadcast bundle; slave side is the arbiter, master side drives the FUs.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int XLEN   = CDB_XLEN,
    parameter int TAG_W  = CDB_TAG_W
) ();

    logic                             squash;
    logic [NUM_FU-1:0]                fu_done;
    logic [NUM_FU-1:0][XLEN-1:0]      fu_result;
    logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag;
    logic [NUM_FU-1:0]                insns_ready;
    logic [NUM_FU-1:0]                cdb_select;
    logic                             cdb_valid;
    logic [XLEN-1:0]                  cdb_value;
    logic [TAG_W-1:0]                 cdb_tag;
    logic                             overflow_err;

    modport slave (
        input  squash, fu_done, fu_result, fu_tag,
        output insns_ready, cdb_select, cdb_valid, cdb_value, cdb_tag, overflow_err
    );

    modport master (
        output squash, fu_done, fu_result, fu_tag,
        input  insns_ready, cdb_select, cdb_valid, cdb_value, cdb_tag, overflow_err
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above i_ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU result holding slots with round-robin CDB broadcast.
// Build option: CDB_ALU_PRIORITY_EN gives the ALU slot absolute priority over round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int XLEN   = CDB_XLEN,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic          clock,
    input  logic          reset_n,
    cdb_arbiter_if.slave  bus
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]            r_valid;
    logic [NUM_FU-1:0][XLEN-1:0]  r_value;
    logic [NUM_FU-1:0][TAG_W-1:0] r_tag;
    logic [PW-1:0]                r_rr_ptr;
    logic                         r_overflow_err;

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_rr_gnt;
    logic [PW-1:0]     w_rr_idx;
    logic              w_rr_any;
    logic [NUM_FU-1:0] w_gnt_raw;
    logic [PW-1:0]     w_gnt_idx;
    logic              w_any_raw;
    logic              w_adv_raw;
    logic [NUM_FU-1:0] w_gnt;
    logic              w_any;
    logic              w_adv;
    logic [NUM_FU-1:0] w_load;
    logic [NUM_FU-1:0] w_drop;

`ifdef CDB_ALU_PRIORITY_EN
    localparam int ALU = int'(FU_ALU);

    // ALU is masked out of the rotation; its grants never move the pointer.
    assign w_req = r_valid & ~(NUM_FU'(1) << ALU);

    always_comb begin
        w_gnt_raw = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
        w_any_raw = w_rr_any;
        w_adv_raw = w_rr_any;
        if (r_valid[ALU]) begin
            w_gnt_raw = NUM_FU'(1) << ALU;
            w_gnt_idx = PW'(ALU);
            w_any_raw = 1'b1;
            w_adv_raw = 1'b0;
        end
    end
`else
    assign w_req     = r_valid;
    assign w_gnt_raw = w_rr_gnt;
    assign w_gnt_idx = w_rr_idx;
    assign w_any_raw = w_rr_any;
    assign w_adv_raw = w_rr_any;
`endif

    rr_arbiter #(.N(NUM_FU), .PW(PW)) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // A squash kills this cycle's broadcast outright.
    assign w_gnt  = bus.squash ? '0 : w_gnt_raw;
    assign w_any  = w_any_raw & ~bus.squash;
    assign w_adv  = w_adv_raw & ~bus.squash;
    assign w_load = bus.fu_done & (~r_valid | w_gnt);
    assign w_drop = bus.fu_done & r_valid & ~w_gnt & {NUM_FU{~bus.squash}};

    assign bus.insns_ready  = r_valid;
    assign bus.cdb_select   = w_gnt;
    assign bus.cdb_valid    = w_any;
    assign bus.overflow_err = r_overflow_err;

    always_comb begin
        bus.cdb_value = '0;
        bus.cdb_tag   = '0;
        if (w_any) begin
            bus.cdb_value = r_value[w_gnt_idx];
            bus.cdb_tag   = r_tag[w_gnt_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid        <= '0;
            r_rr_ptr       <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_adv) begin
                r_rr_ptr <= (w_gnt_idx == PW'(NUM_FU - 1)) ? '0 : w_gnt_idx + PW'(1);
            end
            if (|w_drop) begin
                r_overflow_err <= 1'b1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (bus.squash) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (w_gnt[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: it is only visible through a set valid bit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_load[i]) begin
                r_value[i] <= bus.fu_result[i];
                r_tag[i]   <= bus.fu_tag[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a slot model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    cdb_arbiter_if ifc ();

    cdb_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the holding slots as plain arrays.
    bit          m_valid [4];
    logic [31:0] m_val   [4];
    logic [5:0]  m_tag   [4];
    int          m_ptr;
    bit          m_ovf;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
        m_ovf = 1'b0;
    endfunction

    // Slot chosen this cycle, or -1 when nothing broadcasts.
    function automatic int exp_grant();
        if (ifc.squash) return -1;
`ifdef CDB_ALU_PRIORITY_EN
        if (m_valid[int'(FU_ALU)]) return int'(FU_ALU);
        for (int k = 0; k < 4; k++) begin
            int j = (m_ptr + k) % 4;
            if (j != int'(FU_ALU) && m_valid[j]) return j;
        end
`else
        for (int k = 0; k < 4; k++) begin
            int j = (m_ptr + k) % 4;
            if (m_valid[j]) return j;
        end
`endif
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic void model_update();
        int g = exp_grant();
        for (int i = 0; i < 4; i++) begin
            if (ifc.squash) begin
                m_valid[i] = 1'b0;
            end else if (ifc.fu_done[i] && (!m_valid[i] || g == i)) begin
                m_valid[i] = 1'b1;
                m_val[i]   = ifc.fu_result[i];
                m_tag[i]   = ifc.fu_tag[i];
            end else if (ifc.fu_done[i]) begin
                m_ovf = 1'b1;
            end else if (g == i) begin
                m_valid[i] = 1'b0;
            end
        end
`ifdef CDB_ALU_PRIORITY_EN
        if (g >= 0 && g != int'(FU_ALU)) m_ptr = (g + 1) % 4;
`else
        if (g >= 0) m_ptr = (g + 1) % 4;
`endif
    endfunction

    task automatic drive(input logic [3:0] done, input logic sq);
        ifc.fu_done = done;
        ifc.squash  = sq;
        for (int i = 0; i < 4; i++) begin
            ifc.fu_result[i] = $urandom;
            ifc.fu_tag[i]    = 6'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
        ifc.fu_done = '0;
        ifc.squash  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        ifc.fu_done = '0;
        ifc.squash  = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", ifc.insns_ready); end
        checks++; if (ifc.cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifc.cdb_valid); end
        checks++; if (ifc.overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ifc.overflow_err); end
        drive(4'b0101, 1'b0);
        tick();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0001) begin errors++; $display("FAIL pre_rst_sel got %b exp 0001", ifc.cdb_select); end
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0000) begin errors++; $display("FAIL async_rst_sel got %b exp 0000", ifc.cdb_select); end
        checks++; if (ifc.cdb_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b exp 0", ifc.cdb_valid); end
        checks++; if (ifc.cdb_value !== 32'h0) begin errors++; $display("FAIL async_rst_value got %h exp 0", ifc.cdb_value); end
        checks++; if (ifc.cdb_tag !== 6'h0) begin errors++; $display("FAIL async_rst_tag got %h exp 0", ifc.cdb_tag); end
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL async_rst_ready got %b exp 0000", ifc.insns_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL post_rst_ready got %b exp 0000", ifc.insns_ready); end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0010, 1'b0);
        ifc.fu_result[1] = 32'hDEAD;
        ifc.fu_tag[1]    = 6'd5;
        tick();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0010) begin errors++; $display("FAIL single_sel got %b exp 0010", ifc.cdb_select); end
        checks++; if (ifc.cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ifc.cdb_valid); end
        checks++; if (ifc.cdb_tag !== 6'd5) begin errors++; $display("FAIL single_tag got %0d exp 5", ifc.cdb_tag); end
        checks++; if (ifc.cdb_value !== 32'hDEAD) begin errors++; $display("FAIL single_value got %h exp DEAD", ifc.cdb_value); end
        tick();
        #1;
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL single_drain got %b exp 0000", ifc.insns_ready); end
        checks++; if (ifc.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", ifc.cdb_valid); end
    endtask

    task automatic test_fairness();
        do_reset();
        drive(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) ifc.fu_tag[i] = 6'(i + 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (ifc.cdb_select !== 4'(1 << k)) begin errors++; $display("FAIL rr_sel step %0d got %b exp %b", k, ifc.cdb_select, 4'(1 << k)); end
            checks++; if (ifc.cdb_tag !== 6'(k + 1)) begin errors++; $display("FAIL rr_tag step %0d got %0d exp %0d", k, ifc.cdb_tag, k + 1); end
            tick();
        end
        #1;
        checks++; if (ifc.cdb_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got %b exp 0", ifc.cdb_valid); end
    endtask

    task automatic test_refill();
        do_reset();
        drive(4'b1000, 1'b0);
        ifc.fu_tag[3] = 6'd7;
        tick();
        drive(4'b1000, 1'b0);
        ifc.fu_tag[3] = 6'd9;
        #1;
        checks++; if (ifc.cdb_select !== 4'b1000) begin errors++; $display("FAIL refill_sel got %b exp 1000", ifc.cdb_select); end
        checks++; if (ifc.cdb_tag !== 6'd7) begin errors++; $display("FAIL refill_old_tag got %0d exp 7", ifc.cdb_tag); end
        tick();
        #1;
        checks++; if (ifc.insns_ready !== 4'b1000) begin errors++; $display("FAIL refill_ready got %b exp 1000", ifc.insns_ready); end
        checks++; if (ifc.cdb_tag !== 6'd9) begin errors++; $display("FAIL refill_new_tag got %0d exp 9", ifc.cdb_tag); end
        checks++; if (ifc.overflow_err !== 1'b0) begin errors++; $display("FAIL refill_ovf got %b exp 0", ifc.overflow_err); end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'b0011, 1'b0);
        ifc.fu_tag[0] = 6'd1;
        ifc.fu_tag[1] = 6'd2;
        tick();
        drive(4'b0010, 1'b0);
        ifc.fu_tag[1] = 6'd15;
        #1;
        checks++; if (ifc.cdb_select !== 4'b0001) begin errors++; $display("FAIL ovf_first_sel got %b exp 0001", ifc.cdb_select); end
        tick();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0010) begin errors++; $display("FAIL ovf_second_sel got %b exp 0010", ifc.cdb_select); end
        checks++; if (ifc.cdb_tag !== 6'd2) begin errors++; $display("FAIL ovf_kept_tag got %0d exp 2", ifc.cdb_tag); end
        checks++; if (ifc.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ifc.overflow_err); end
        tick();
        tick();
        #1;
        checks++; if (ifc.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ifc.overflow_err); end
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL ovf_drain got %b exp 0000", ifc.insns_ready); end
    endtask

    task automatic test_squash();
        do_reset();
        drive(4'b0101, 1'b0);
        tick();
        drive(4'b0000, 1'b1);
        #1;
        checks++; if (ifc.cdb_valid !== 1'b0) begin errors++; $display("FAIL squash_valid got %b exp 0", ifc.cdb_valid); end
        checks++; if (ifc.cdb_select !== 4'b0000) begin errors++; $display("FAIL squash_sel got %b exp 0000", ifc.cdb_select); end
        tick();
        #1;
        checks++; if (ifc.insns_ready !== 4'b0000) begin errors++; $display("FAIL squash_clear got %b exp 0000", ifc.insns_ready); end
        drive(4'b0011, 1'b0);
        tick();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0001) begin errors++; $display("FAIL squash_ptr_kept got %b exp 0001", ifc.cdb_select); end
        tick();
        tick();
    endtask

    task automatic test_alu_priority();
        logic [3:0] first;
        logic [3:0] second;
`ifdef CDB_ALU_PRIORITY_EN
        first  = 4'b0001;
        second = 4'b0100;
`else
        first  = 4'b0100;
        second = 4'b0001;
`endif
        do_reset();
        drive(4'b0010, 1'b0);
        tick();
        #1;
        checks++; if (ifc.cdb_select !== 4'b0010) begin errors++; $display("FAIL prio_setup_sel got %b exp 0010", ifc.cdb_select); end
        tick();
        drive(4'b0101, 1'b0);
        tick();
        #1;
        checks++; if (ifc.cdb_select !== first) begin errors++; $display("FAIL prio_first got %b exp %b", ifc.cdb_select, first); end
        tick();
        #1;
        checks++; if (ifc.cdb_select !== second) begin errors++; $display("FAIL prio_second got %b exp %b", ifc.cdb_select, second); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int         g;
            logic [3:0] e_sel;
            logic [31:0] e_val;
            logic [5:0]  e_tag;
            if (c == 200) do_reset();
            drive(4'($urandom & $urandom), ($urandom_range(0, 15) == 0));
            #1;
            g     = exp_grant();
            e_sel = (g < 0) ? 4'b0000 : 4'(1 << g);
            e_val = (g < 0) ? 32'h0 : m_val[g];
            e_tag = (g < 0) ? 6'h0 : m_tag[g];
            checks++; if (ifc.cdb_select !== e_sel) begin errors++; $display("FAIL rand_sel cyc %0d got %b exp %b", c, ifc.cdb_select, e_sel); end
            checks++; if (ifc.cdb_valid !== (g >= 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, ifc.cdb_valid, (g >= 0)); end
            checks++; if (ifc.cdb_value !== e_val) begin errors++; $display("FAIL rand_value cyc %0d got %h exp %h", c, ifc.cdb_value, e_val); end
            checks++; if (ifc.cdb_tag !== e_tag) begin errors++; $display("FAIL rand_tag cyc %0d got %h exp %h", c, ifc.cdb_tag, e_tag); end
            checks++; if (ifc.insns_ready !== model_ready()) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, ifc.insns_ready, model_ready()); end
            checks++; if (ifc.overflow_err !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b exp %b", c, ifc.overflow_err, m_ovf); end
            tick();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        ifc.squash    = 1'b0;
        ifc.fu_done   = '0;
        ifc.fu_result = '0;
        ifc.fu_tag    = '0;
        model_clear();
        test_reset();
        test_single();
        test_fairness();
        test_refill();
        test_overflow();
        test_squash();
        test_alu_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
